// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering four requesters onto a shared 4:1 mux with registered outputs.
// Optional forced rotation after MAX_HOLD cycles: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int DW       = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   input  logic [DW-1:0] in_c,
   input  logic [DW-1:0] in_d,
   output logic [1:0]    sel,
   output logic [3:0]    grant,
   output logic [DW-1:0] out_x,
   output logic          out_vld
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t        state;
   logic [1:0]    last_ptr;
   logic [DW-1:0] words [4];
   logic [1:0]    pick_last;
   logic [1:0]    pick_sel;
   logic          others;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
      $error("MAX_HOLD must be within 1..255");
   end

   assign words[0] = in_a;
   assign words[1] = in_b;
   assign words[2] = in_c;
   assign words[3] = in_d;

   // First requester found scanning ptr+1 .. ptr+4 (mod 4).
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = ptr;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   assign pick_last = pick(req, last_ptr);
   assign pick_sel  = pick(req, sel);
   assign others    = |(req & ~(4'b0001 << sel));

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         out_x    <= '0;
         out_vld  <= 1'b0;
         last_ptr <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt <= '0;
`endif
      end else begin
         out_vld <= (state == GRANT) && req[sel];
         // Only an owner's word is captured, so out_x holds while idle.
         if (state == GRANT) begin
            out_x <= words[sel];
         end

         if (state == IDLE) begin
            if (|req) begin
               state <= GRANT;
               sel   <= pick_last;
               grant <= 4'b0001 << pick_last;
`ifdef MUX_ARB_TIMEOUT_EN
               hold_cnt <= '0;
`endif
            end
         end else begin
            if (!req[sel]) begin
               // Release: req[sel] is low, so the pointer scan skips the old owner.
               last_ptr <= sel;
               if (|req) begin
                  sel   <= pick_sel;
                  grant <= 4'b0001 << pick_sel;
`ifdef MUX_ARB_TIMEOUT_EN
                  hold_cnt <= '0;
`endif
               end else begin
                  state <= IDLE;
                  grant <= '0;
               end
            end
`ifdef MUX_ARB_TIMEOUT_EN
            else if (hold_cnt == HOLD_TOP && others) begin
               last_ptr <= sel;
               sel      <= pick_sel;
               grant    <= 4'b0001 << pick_sel;
               hold_cnt <= '0;
            end else if (hold_cnt != HOLD_TOP) begin
               hold_cnt <= hold_cnt + 8'd1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: behavioural model feeding a scoreboard, plus directed checkpoints.
module tb_mux_rr_arbiter;
   localparam int MAX_HOLD = 4;
   localparam int DW       = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req   = '0;
   logic [DW-1:0] in_a  = '0;
   logic [DW-1:0] in_b  = '0;
   logic [DW-1:0] in_c  = '0;
   logic [DW-1:0] in_d  = '0;
   logic [1:0]    sel;
   logic [3:0]    grant;
   logic [DW-1:0] out_x;
   logic          out_vld;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .DW(DW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .in_a   (in_a),
      .in_b   (in_b),
      .in_c   (in_c),
      .in_d   (in_d),
      .sel    (sel),
      .grant  (grant),
      .out_x  (out_x),
      .out_vld(out_vld)
   );

   typedef struct packed {
      logic [3:0]    grant;
      logic [1:0]    sel;
      logic [DW-1:0] x;
      logic          vld;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TIMEOUT = 1'b1;
`else
   localparam bit TIMEOUT = 1'b0;
`endif

   function automatic int pick(input logic [3:0] r, input int from);
      for (int k = 1; k <= 4; k++) begin
         if (r[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [DW-1:0] word_of(input int s);
      case (s)
         0:       return in_a;
         1:       return in_b;
         2:       return in_c;
         default: return in_d;
      endcase
   endfunction

   // Reference model: owner index (-1 = idle), rotation pointer and hold count as plain ints.
   initial begin
      int            owner;
      int            last_p;
      int            hold;
      logic [1:0]    m_sel;
      logic [DW-1:0] m_x;
      logic          m_vld;
      exp_t          e;
      owner = -1; last_p = 3; hold = 0; m_sel = '0; m_x = '0; m_vld = 1'b0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            owner = -1; last_p = 3; hold = 0; m_sel = '0; m_x = '0; m_vld = 1'b0;
         end else begin
            m_vld = (owner >= 0) && req[owner];
            if (owner >= 0) m_x = word_of(owner);
            if (owner < 0) begin
               if (req != 4'b0) begin
                  owner = pick(req, last_p);
                  hold  = 0;
               end
            end else if (!req[owner]) begin
               last_p = owner;
               owner  = (req != 4'b0) ? pick(req, last_p) : -1;
               hold   = 0;
            end else if (TIMEOUT) begin
               if (hold == MAX_HOLD - 1 && (req & ~(4'b0001 << owner)) != 4'b0) begin
                  last_p = owner;
                  owner  = pick(req, last_p);
                  hold   = 0;
               end else if (hold < MAX_HOLD - 1) begin
                  hold++;
               end
            end
            if (owner >= 0) m_sel = 2'(owner);
         end
         e.grant = (owner >= 0) ? 4'(1 << owner) : 4'b0;
         e.sel   = m_sel;
         e.x     = m_x;
         e.vld   = m_vld;
         sb.push_back(e);
      end
   end

   // Monitor: one expected entry per clock edge, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (grant !== e.grant || sel !== e.sel || out_x !== e.x || out_vld !== e.vld) begin
               fails++;
               $display("FAIL scoreboard t=%0t grant=%b exp %b sel=%0d exp %0d out_x=%0d exp %0d out_vld=%b exp %b",
                        $time, grant, e.grant, sel, e.sel, out_x, e.x, out_vld, e.vld);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end else begin
         $display("[TB] %s = %0h", name, act);
      end
   endtask

   initial begin
      // T1: reset held with all requests high
      rst_n = 1'b0; req = 4'hF;
      tick(2);
      check("t1_grant", 8'(grant), 8'h0);
      check("t1_sel", 8'(sel), 8'h0);
      check("t1_out_x", 8'(out_x), 8'h0);
      check("t1_out_vld", 8'(out_vld), 8'h0);

      // T2: single request from source 2
      rst_n = 1'b1; req = 4'b0100; in_c = 2'b10;
      tick();
      check("t2_grant", 8'(grant), 8'h4);
      check("t2_sel", 8'(sel), 8'h2);
      tick();
      check("t2_out_x", 8'(out_x), 8'h2);
      check("t2_out_vld", 8'(out_vld), 8'h1);

      // T5: release with nothing pending
      req = 4'b0000;
      tick();
      check("t5_grant", 8'(grant), 8'h0);
      check("t5_out_vld", 8'(out_vld), 8'h0);
      check("t5_sel", 8'(sel), 8'h2);

      // T3: rotation, each owner drops after three cycles
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req = 4'hF;
      tick();
      for (int k = 0; k < 5; k++) begin
         req = 4'hF;
         check($sformatf("t3_grant_%0d", k), 8'(grant), 8'(1 << (k % 4)));
         tick(2);
         req = 4'hF & ~4'(1 << (k % 4));
         tick();
      end

      // T4: two sources requesting constantly
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req = 4'b0011;
      for (int c = 0; c < 16; c++) begin
         tick();
         check($sformatf("t4_grant_%0d", c), 8'(grant),
               (TIMEOUT && ((c / 4) % 2 == 1)) ? 8'h2 : 8'h1);
      end

      // T6: reset while source 3 owns the mux
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req = 4'b1000;
      tick();
      check("t6_grant_before", 8'(grant), 8'h8);
      rst_n = 1'b0;
      tick();
      check("t6_grant_rst", 8'(grant), 8'h0);
      check("t6_sel_rst", 8'(sel), 8'h0);
      check("t6_out_x_rst", 8'(out_x), 8'h0);
      check("t6_out_vld_rst", 8'(out_vld), 8'h0);
      rst_n = 1'b1; req = 4'b1001;
      tick();
      check("t6_grant_after", 8'(grant), 8'h1);

      // Randomized traffic with occasional resets; the scoreboard checks every cycle
      for (int i = 0; i < 800; i++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
         in_a = DW'($urandom); in_b = DW'($urandom);
         in_c = DW'($urandom); in_d = DW'($urandom);
         tick();
      end

      rst_n = 1'b1; req = 4'b0;
      tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
